rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single register-file write port (regWrite / rd / writeData) between two writeback sources: the ALU result path and the memory/load result path. It arbitrates with fixed priority to MEM, plus a starvation guard that forces an ALU grant after a bounded wait. The granted write is registered for one cycle before it drives the register file. The block sits between the execute/memory writeback stages and RegisterFile, and also keeps a committed-write counter for debug.

## Interface
Parameters:
- MAX_WAIT, default 3: consecutive lost cycles after which the ALU is forced to win (range 1..15).
- CNT_W, default 16: width of the committed-write counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- alu_valid  input  1  ALU writeback request.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- alu_ready  output  1  ALU request accepted this cycle (combinational).
- mem_valid  input  1  MEM writeback request.
- mem_rd  input  5  MEM destination register.
- mem_data  input  32  MEM load data.
- mem_ready  output  1  MEM request accepted this cycle (combinational).
- regWrite  output  1  write enable to RegisterFile (registered).
- rd  output  5  write address to RegisterFile (registered).
- writeData  output  32  write data to RegisterFile (registered).
- alu_starved  output  1  high while the starvation override is active (combinational).
- wr_count  output  CNT_W  number of committed writes since reset (registered).

## Operation
- Handshake: a transfer occurs when valid && ready in the same cycle. A source holds valid, rd and data stable until accepted. A source may drop valid only after a transfer.
- wait_cnt (4 bit) is internal. starve = (wait_cnt >= MAX_WAIT); alu_starved = starve.
- mem_ready = !(alu_valid && starve).
- alu_ready = !mem_valid || starve.
- At most one transfer per cycle; both ready signals are never high together while both valids are high.
- wait_cnt rules:
  - Cleared on an ALU transfer, or when alu_valid is low.
  - Incremented when alu_valid && !alu_ready.
  - Saturates at 15.
- Capture: on a transfer, the winner's rd and data load into the output register.
  - regWrite is set to 1 if the captured rd != 0, and 0 if rd == 0. An rd=0 write is accepted and discarded.
  - With no transfer, regWrite is cleared to 0. rd and writeData hold their last values.
- wr_count increments on every cycle in which regWrite is 1, and wraps modulo 2^CNT_W.
- A transfer still completes if both sources target the same rd. Writes commit in grant order, so the later grant's value persists in the register file.

## Timing
- Reset values: regWrite=0, rd=0, writeData=0, wr_count=0, wait_cnt=0. Consequently alu_starved=0 after reset.
- alu_ready and mem_ready follow the reset-state equations with wait_cnt=0: alu_ready = !mem_valid, mem_ready = 1.
- Latency: transfer at edge N means regWrite/rd/writeData are valid during cycle N+1, as a one-cycle pulse per transfer. RegisterFile commits at edge N+1.
- Throughput: one write per cycle, sustained back-to-back from either source or alternating.
- Starvation bound: with mem_valid held high and alu_valid high, the ALU transfers on the (MAX_WAIT+1)th cycle of its request. During that cycle mem_ready=0.
- rst asserted mid-operation:
  - Any transfer presented in the rst cycle is ignored. ready outputs may be high, but nothing is captured.
  - The output register clears at that edge, so a write captured in the previous cycle is suppressed if rst is high during its output cycle.
  - wait_cnt and wr_count clear.
- No combinational path from regWrite/rd/writeData back to the ready outputs.

## Test plan
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle, mem idle -> alu_ready=1; next cycle regWrite=1, rd=5, writeData=0xDEADBEEF; following cycle regWrite=0, wr_count=1.
- Simultaneous requests, MAX_WAIT=3: ALU rd=1 data=0x11, MEM rd=2 data=0x22, both valid at cycle 0, MEM idle after its grant -> MEM granted cycle 0, ALU granted cycle 1; writes to rd=2 then rd=1 on consecutive cycles.
- Starvation: mem_valid held high with new data every cycle, alu_valid held high from cycle 0, MAX_WAIT=3 -> alu_ready=0 for cycles 0-2; cycle 3 has alu_starved=1, alu_ready=1, mem_ready=0; wait_cnt returns to 0 in cycle 4.
- rd=0 discard: MEM rd=0 data=0xFFFFFFFF accepted -> mem_ready=1, regWrite stays 0, wr_count unchanged.
- Reset mid-stream: ALU transfer at cycle 4, rst=1 in cycle 5 -> regWrite=0 in cycles 5 and 6, wr_count=0, wait_cnt=0.
- Counter wrap: CNT_W=4, 17 back-to-back ALU writes to rd=7 -> wr_count reads 1 after the last commit.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between the ALU and MEM writeback paths.
// MEM has fixed priority; a starvation guard forces an ALU grant after MAX_WAIT lost cycles.
module rf_write_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      mem_data,
    output logic             mem_ready,
    output logic             regWrite,
    output logic [4:0]       rd,
    output logic [31:0]      writeData,
    output logic             alu_starved,
    output logic [CNT_W-1:0] wr_count
);

    logic [3:0]  wait_cnt;
    logic        starve;
    logic        regwrite_q;
    logic        alu_xfer;
    logic        mem_xfer;
    logic [4:0]  win_rd;
    logic [31:0] win_data;

    assign starve      = (wait_cnt >= 4'(MAX_WAIT));
    assign alu_starved = starve;
    assign mem_ready   = !(alu_valid && starve);
    assign alu_ready   = !mem_valid || starve;

    // The ready equations guarantee at most one of these is high in any cycle.
    assign alu_xfer = alu_valid && alu_ready;
    assign mem_xfer = mem_valid && mem_ready;

    assign win_rd   = alu_xfer ? alu_rd   : mem_rd;
    assign win_data = alu_xfer ? alu_data : mem_data;

    // Gated by rst so a write captured just before reset never reaches the register file.
    assign regWrite = regwrite_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            rd         <= '0;
            writeData  <= '0;
            wr_count   <= '0;
            wait_cnt   <= '0;
        end else begin
            wr_count <= wr_count + {{(CNT_W-1){1'b0}}, regwrite_q};
            if (alu_xfer || mem_xfer) begin
                regwrite_q <= (win_rd != 5'd0);
                rd         <= win_rd;
                writeData  <= win_data;
            end else begin
                regwrite_q <= 1'b0;
            end
            if (alu_valid && !alu_ready)
                wait_cnt <= (wait_cnt == 4'd15) ? 4'd15 : wait_cnt + 4'd1;
            else
                wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed checks of rf_write_arbiter against a queue-free behavioural model.
module tb_rf_write_arbiter;

    localparam int MAX_WAIT = 3;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alu_valid = 1'b0;
    logic [4:0]       alu_rd = '0;
    logic [31:0]      alu_data = '0;
    logic             alu_ready;
    logic             mem_valid = 1'b0;
    logic [4:0]       mem_rd = '0;
    logic [31:0]      mem_data = '0;
    logic             mem_ready;
    logic             regWrite;
    logic [4:0]       rd;
    logic [31:0]      writeData;
    logic             alu_starved;
    logic [CNT_W-1:0] wr_count;

    rf_write_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .regWrite(regWrite), .rd(rd), .writeData(writeData),
        .alu_starved(alu_starved), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: what the register-file port should show, and how long the ALU has been losing.
    bit          m_we = 0;
    int          m_rd = 0;
    logic [31:0] m_data = '0;
    int          m_commits = 0;
    int          m_lost = 0;
    bit          skip_cmp = 1;
    bit          x_alu, x_mem, x_lost_cycle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare at negedge, then advance the model across the posedge.
    task automatic step();
        bit e_starve, e_aready, e_mready;
        @(negedge clk);
        e_starve = (m_lost >= MAX_WAIT);
        e_mready = !(alu_valid && e_starve);
        e_aready = !mem_valid || e_starve;
        if (!skip_cmp) begin
            chk("m_alu_ready", alu_ready, e_aready);
            chk("m_mem_ready", mem_ready, e_mready);
            chk("m_starved", alu_starved, e_starve);
            chk("m_regWrite", regWrite, m_we && !rst);
            chk("m_rd", rd, m_rd);
            chk("m_writeData", writeData, m_data);
            chk("m_wr_count", wr_count, m_commits % (1 << CNT_W));
        end
        x_alu = alu_valid && e_aready && !rst;
        x_mem = mem_valid && e_mready && !rst && !x_alu;
        x_lost_cycle = alu_valid && !e_aready;
        @(posedge clk);
        #1;
        if (rst) begin
            m_we = 0; m_rd = 0; m_data = '0; m_commits = 0; m_lost = 0;
        end else begin
            m_commits = m_commits + (m_we ? 1 : 0);
            if (x_alu) begin
                m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data;
            end else if (x_mem) begin
                m_we = (mem_rd != 0); m_rd = mem_rd; m_data = mem_data;
            end else begin
                m_we = 0;
            end
            m_lost = x_lost_cycle ? ((m_lost < 15) ? m_lost + 1 : 15) : 0;
        end
        skip_cmp = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_rd", rd, 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_starved", alu_starved, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 1);

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 chk("single_alu_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        #1;
        chk("single_regWrite", regWrite, 1);
        chk("single_rd", rd, 5);
        chk("single_data", writeData, 32'hDEADBEEF);
        step();
        #1;
        chk("single_regWrite_off", regWrite, 0);
        chk("single_wr_count", wr_count, 1);

        // Simultaneous requests: MEM first, then ALU
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        mem_valid = 1; mem_rd = 2; mem_data = 32'h22;
        #1;
        chk("sim_mem_ready", mem_ready, 1);
        chk("sim_alu_ready", alu_ready, 0);
        step();
        mem_valid = 0;
        #1;
        chk("sim_alu_ready2", alu_ready, 1);
        chk("sim_rd_first", rd, 2);
        chk("sim_data_first", writeData, 32'h22);
        step();
        alu_valid = 0;
        #1;
        chk("sim_regWrite2", regWrite, 1);
        chk("sim_rd_second", rd, 1);
        chk("sim_data_second", writeData, 32'h11);
        step();

        // Starvation: MEM streams, ALU forced through on its 4th cycle
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        mem_valid = 1; mem_rd = 4;
        for (int c = 0; c < 4; c++) begin
            mem_data = 32'h100 + c;
            #1;
            chk("starve_alu_ready", alu_ready, (c == 3) ? 1 : 0);
            chk("starve_mem_ready", mem_ready, (c == 3) ? 0 : 1);
            chk("starve_flag", alu_starved, (c == 3) ? 1 : 0);
            step();
        end
        chk("starve_alu_won_rd", rd, 3);
        alu_rd = 6; alu_data = 32'h66;
        #1;
        chk("starve_cleared", alu_starved, 0);
        chk("starve_mem_again", mem_ready, 1);
        step();
        mem_valid = 0;
        step();
        alu_valid = 0;
        step();

        // rd=0 accepted and discarded
        mem_valid = 1; mem_rd = 0; mem_data = 32'hFFFFFFFF;
        #1 chk("rd0_mem_ready", mem_ready, 1);
        step();
        mem_valid = 0;
        #1;
        chk("rd0_regWrite", regWrite, 0);
        chk("rd0_rd", rd, 0);
        chk("rd0_data", writeData, 32'hFFFFFFFF);
        step();

        // Reset while a captured write is in its output cycle
        do_reset();
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        step();
        alu_valid = 0; rst = 1;
        #1 chk("midrst_regWrite_c5", regWrite, 0);
        step();
        rst = 0;
        #1;
        chk("midrst_regWrite_c6", regWrite, 0);
        chk("midrst_wr_count", wr_count, 0);
        chk("midrst_starved", alu_starved, 0);
        step();

        // Counter wrap with a 4-bit counter
        do_reset();
        alu_valid = 1; alu_rd = 7;
        for (int i = 0; i < 17; i++) begin
            alu_data = 32'(i);
            step();
        end
        alu_valid = 0;
        step();
        #1 chk("wrap_wr_count", wr_count, 1);

        // Randomized traffic with occasional reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!alu_valid || x_alu) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!mem_valid || x_mem) begin
                mem_valid = ($urandom_range(0, 99) < 70);
                mem_rd    = 5'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            rst = ($urandom_range(0, 99) < 2);
            step();
        end
        rst = 0; alu_valid = 0; mem_valid = 0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
